// File: rtl/lift_rd_sched_pkg.sv
// Shared constants and types for the lift read scheduler.
// A half-buffer is one 240-bit line of eight 30-bit banks, read as 6 or 7 words depending on mode.
package lift_rd_sched_pkg;

  localparam int WORD_W  = 30;
  localparam int BANKS   = 8;
  localparam int LINE_W  = 240;
  localparam int N_MODE0 = 7;
  localparam int N_MODE1 = 6;

  typedef enum logic {IDLE, RUN} state_e;

  // Address of the final word of a half for the given mode.
  function automatic logic [2:0] last_word(input logic mode);
    return mode ? 3'(N_MODE1 - 1) : 3'(N_MODE0 - 1);
  endfunction

endpackage

// File: rtl/lift_rd_sched_fifo2.sv
// Two-entry output FIFO carrying a buffer line plus its end-of-half tag.
// A push and a pop in the same cycle are both honoured, even when the FIFO is full.
module lift_rd_fifo2
  import lift_rd_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [LINE_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic              valid,
  output logic [LINE_W-1:0] data,
  output logic              last,
  output logic [1:0]        count
);

  logic [LINE_W-1:0] data_q [2];
  logic [LINE_W-1:0] data_d [2];
  logic [1:0]        last_q, last_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    data_d   = data_q;
    last_d   = last_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      data_d[wr_ptr_q] = push_data;
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      data_q    <= data_d;
      last_q    <= last_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // The head entry is only overwritten while it is being popped, so data holds under backpressure.
  assign valid = (count_q != 2'd0);
  assign data  = data_q[rd_ptr_q];
  assign last  = valid & last_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/lift_rd_sched.sv
// Read scheduler: drains filled result-buffer halves word by word into a valid/ready stream,
// throttling reads so that the 2-entry output FIFO can never overflow.
module lift_rd_sched
  import lift_rd_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_mode,
  input  logic              cfg_mode_ld,
  input  logic              lift_idle,
  input  logic              buf_write_done,
  output logic              buf_mode,
  output logic [2:0]        buf_rd_addr,
  output logic              buf_rd_en,
  input  logic [LINE_W-1:0] buf_dout,
  output logic              lift_stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_data,
  output logic              out_last,
  output logic              err_overflow
);

  state_e     state_q, state_d;
  logic [1:0] full_cnt_q, full_cnt_d;
  logic [2:0] k_q, k_d;
  logic       inflight_q, inflight_d;
  logic       inflight_last_q, inflight_last_d;
  logic       mode_q, mode_d;
  logic       err_q, err_d;
  logic [1:0] fifo_cnt;
  logic [1:0] occupancy;
  logic       pop, issue, last_issue, quiescent;

  // A read issued now lands in the FIFO at the end of the next cycle; counting this cycle's pop
  // as free space is what allows one word per cycle with only two entries.
  assign pop        = out_valid & out_ready;
  assign occupancy  = {1'b0, inflight_q} + fifo_cnt - {1'b0, pop};
  assign issue      = (state_q == RUN) && (occupancy < 2'd2);
  assign last_issue = issue && (k_q == last_word(mode_q));
  assign quiescent  = (state_q == IDLE) && (full_cnt_q == 2'd0) && (fifo_cnt == 2'd0)
                      && !inflight_q && lift_idle;

  always_comb begin
    full_cnt_d = full_cnt_q;
    err_d      = err_q;
    if (buf_write_done && (full_cnt_q == 2'd2)) begin
      err_d = 1'b1;
    end
    case ({buf_write_done, last_issue})
      2'b10:   if (full_cnt_q != 2'd2) full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    mode_d          = (cfg_mode_ld && quiescent) ? cfg_mode : mode_q;
    case (state_q)
      IDLE: begin
        if (full_cnt_q != 2'd0) state_d = RUN;
      end
      RUN: begin
        if (last_issue) begin
          k_d = 3'd0;
          if (full_cnt_d == 2'd0) state_d = IDLE;
        end else if (issue) begin
          k_d = k_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      full_cnt_q      <= 2'd0;
      k_q             <= 3'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      mode_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      full_cnt_q      <= full_cnt_d;
      k_q             <= k_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      mode_q          <= mode_d;
      err_q           <= err_d;
    end
  end

  lift_rd_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (buf_dout),
    .push_last (inflight_last_q),
    .pop       (pop),
    .valid     (out_valid),
    .data      (out_data),
    .last      (out_last),
    .count     (fifo_cnt)
  );

  assign buf_mode     = mode_q;
  assign buf_rd_en    = issue;
  assign buf_rd_addr  = issue ? k_q : 3'd0;
  assign lift_stall   = (full_cnt_q == 2'd2);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_lift_rd_sched.sv
// Directed bench for lift_rd_sched with a behavioural result buffer and a stream monitor.
module tb_lift_rd_sched;
  import lift_rd_sched_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  logic cfg_mode = 1'b0, cfg_mode_ld = 1'b0, lift_idle = 1'b1, buf_write_done = 1'b0, out_ready = 1'b0;
  logic buf_mode, buf_rd_en, lift_stall, out_valid, out_last, err_overflow;
  logic [2:0] buf_rd_addr;
  logic [LINE_W-1:0] buf_dout, out_data;

  int tests_run = 0, tests_failed = 0;
  int tb_n = 7, half_base = 0;
  int tb_half;

  logic [2:0]        issue_addr_q [$];
  int                issue_cyc_q  [$];
  logic [LINE_W-1:0] out_data_q   [$];
  logic              out_last_q   [$];
  int                out_cyc_q    [$];
  int cyc = 0, hold_viol = 0, hold_events = 0, addr_viol = 0, stall_cnt = 0;
  logic prev_stalled = 1'b0, prev_last = 1'b0;
  logic [LINE_W-1:0] prev_data = '0;

  always #5 clk = ~clk;

  lift_rd_sched dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_mode       (cfg_mode),
    .cfg_mode_ld    (cfg_mode_ld),
    .lift_idle      (lift_idle),
    .buf_write_done (buf_write_done),
    .buf_mode       (buf_mode),
    .buf_rd_addr    (buf_rd_addr),
    .buf_rd_en      (buf_rd_en),
    .buf_dout       (buf_dout),
    .lift_stall     (lift_stall),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .err_overflow   (err_overflow)
  );

  function automatic logic [LINE_W-1:0] mk(input int h, input int a);
    logic [LINE_W-1:0] v;
    v = '0;
    v[239:224] = 16'hC0DE;
    v[127:96]  = 32'(h * 16 + a);
    v[31:0]    = ~32'(h * 16 + a);
    return v;
  endfunction

  // Result buffer: data one cycle after issue, read half flips after its last word.
  always @(posedge clk) begin
    if (rst) begin
      buf_dout <= '0;
      tb_half  <= 0;
    end else if (buf_rd_en) begin
      buf_dout <= mk(tb_half, int'(buf_rd_addr));
      if (int'(buf_rd_addr) == tb_n - 1) tb_half <= tb_half + 1;
    end
  end

  // Stream monitor, sampling mid-cycle after inputs have settled.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (buf_rd_en) begin
      issue_addr_q.push_back(buf_rd_addr);
      issue_cyc_q.push_back(cyc);
    end
    if (!buf_rd_en && buf_rd_addr != 3'd0) addr_viol++;
    if (lift_stall) stall_cnt++;
    if (!rst && prev_stalled) begin
      hold_events++;
      if (!out_valid || out_data !== prev_data || out_last !== prev_last) hold_viol++;
    end
    if (out_valid && out_ready) begin
      out_data_q.push_back(out_data);
      out_last_q.push_back(out_last);
      out_cyc_q.push_back(cyc);
    end
    prev_stalled = out_valid && !out_ready && !rst;
    prev_data    = out_data;
    prev_last    = out_last;
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_done;
    @(negedge clk);
    buf_write_done = 1'b1;
    @(negedge clk);
    buf_write_done = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #2;
    tests_run++; if (buf_mode !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_buf_mode: got %0b, expected 0", buf_mode); end
    tests_run++; if (buf_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_en: got %0b, expected 0", buf_rd_en); end
    tests_run++; if (buf_rd_addr !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_rd_addr: got %0d, expected 0", buf_rd_addr); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %0b, expected 0", out_valid); end
    tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_last: got %0b, expected 0", out_last); end
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %0h, expected 0", out_data); end
    tests_run++; if (lift_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_lift_stall: got %0b, expected 0", lift_stall); end
    tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %0b, expected 0", err_overflow); end
  endtask

  task automatic test_mode0_single;
    int i0, o0, a0, ok, n_iss, n_out;
    i0 = issue_addr_q.size(); o0 = out_data_q.size(); a0 = addr_viol;
    tb_n = 7; out_ready = 1'b1;
    pulse_done();
    ok = 0;
    for (int c = 0; c < 60 && ok == 0; c++) begin
      @(negedge clk); #2;
      if (out_data_q.size() - o0 >= 7) ok = 1;
    end
    repeat (10) @(negedge clk);
    #2;
    n_iss = issue_addr_q.size() - i0; n_out = out_data_q.size() - o0;
    tests_run++; if (ok != 1) begin tests_failed++; $display("[TB] FAIL mode0_timeout: got %0d words, expected 7", n_out); end
    tests_run++; if (n_iss != 7) begin tests_failed++; $display("[TB] FAIL mode0_issue_count: got %0d, expected 7", n_iss); end
    tests_run++; if (n_out != 7) begin tests_failed++; $display("[TB] FAIL mode0_out_count: got %0d, expected 7", n_out); end
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (i >= n_iss || issue_addr_q[i0+i] !== 3'(i)) begin
        tests_failed++; $display("[TB] FAIL mode0_addr[%0d]: got %0d, expected %0d", i, issue_addr_q[i0+i], i);
      end
    end
    tests_run++;
    if (n_iss < 7 || issue_cyc_q[i0+6] - issue_cyc_q[i0] != 6) begin
      tests_failed++; $display("[TB] FAIL mode0_consecutive: got span %0d, expected 6", issue_cyc_q[i0+6] - issue_cyc_q[i0]);
    end
    tests_run++;
    if (n_iss < 1 || n_out < 1 || out_cyc_q[o0] - issue_cyc_q[i0] != 2) begin
      tests_failed++; $display("[TB] FAIL mode0_latency: got %0d, expected 2", out_cyc_q[o0] - issue_cyc_q[i0]);
    end
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (i >= n_out || out_data_q[o0+i] !== mk(half_base, i) || out_last_q[o0+i] !== (i == 6)) begin
        tests_failed++; $display("[TB] FAIL mode0_word[%0d]: got %0h last %0b, expected %0h last %0b", i, out_data_q[o0+i], out_last_q[o0+i], mk(half_base, i), (i == 6));
      end
    end
    tests_run++; if (addr_viol - a0 != 0) begin tests_failed++; $display("[TB] FAIL mode0_addr_idle: got %0d nonzero idle addrs, expected 0", addr_viol - a0); end
    half_base += 1;
  endtask

  task automatic test_backpressure;
    int o0, h0, e0, ok, n_out;
    o0 = out_data_q.size(); h0 = hold_viol; e0 = hold_events;
    tb_n = 7; out_ready = 1'b0;
    ok = 0;
    for (int c = 0; c < 200 && ok == 0; c++) begin
      @(negedge clk);
      out_ready      = ~out_ready;
      buf_write_done = (c == 0 || c == 6);
      #2;
      if (out_data_q.size() - o0 >= 14) ok = 1;
    end
    buf_write_done = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    n_out = out_data_q.size() - o0;
    tests_run++; if (n_out != 14) begin tests_failed++; $display("[TB] FAIL bp_out_count: got %0d, expected 14", n_out); end
    for (int i = 0; i < 14; i++) begin
      tests_run++;
      if (i >= n_out || out_data_q[o0+i] !== mk(half_base + i / 7, i % 7) || out_last_q[o0+i] !== (i % 7 == 6)) begin
        tests_failed++; $display("[TB] FAIL bp_word[%0d]: got %0h last %0b, expected %0h last %0b", i, out_data_q[o0+i], out_last_q[o0+i], mk(half_base + i / 7, i % 7), (i % 7 == 6));
      end
    end
    tests_run++; if (hold_viol - h0 != 0) begin tests_failed++; $display("[TB] FAIL bp_hold: got %0d unstable stalls, expected 0", hold_viol - h0); end
    tests_run++; if (hold_events - e0 == 0) begin tests_failed++; $display("[TB] FAIL bp_stalls_seen: got 0 stalled cycles, expected at least 1"); end
    half_base += 2;
  endtask

  task automatic test_overflow;
    int i0, n_iss;
    i0 = issue_addr_q.size();
    out_ready = 1'b0;
    pulse_done();
    repeat (3) @(negedge clk);
    pulse_done();
    #2;
    tests_run++; if (lift_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_stall_2nd: got %0b, expected 1", lift_stall); end
    tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_err_early: got %0b, expected 0", err_overflow); end
    pulse_done();
    #2;
    tests_run++; if (err_overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_err_3rd: got %0b, expected 1", err_overflow); end
    tests_run++; if (lift_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_stall_3rd: got %0b, expected 1", lift_stall); end
    repeat (10) @(negedge clk);
    #2;
    n_iss = issue_addr_q.size() - i0;
    tests_run++; if (n_iss > 2) begin tests_failed++; $display("[TB] FAIL ovf_reads: got %0d, expected at most 2", n_iss); end
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    #2;
    tests_run++; if (err_overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got %0b, expected 1", err_overflow); end
    do_reset();
    #2;
    tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_cleared: got %0b, expected 0", err_overflow); end
    half_base = 0;
  endtask

  task automatic test_mode1;
    int o0, s0, ok, n_out;
    out_ready = 1'b1;
    @(negedge clk);
    cfg_mode = 1'b1; cfg_mode_ld = 1'b1;
    #2;
    tests_run++; if (buf_mode !== 1'b0) begin tests_failed++; $display("[TB] FAIL m1_mode_before_edge: got %0b, expected 0", buf_mode); end
    @(negedge clk);
    cfg_mode_ld = 1'b0;
    #2;
    tests_run++; if (buf_mode !== 1'b1) begin tests_failed++; $display("[TB] FAIL m1_mode_loaded: got %0b, expected 1", buf_mode); end
    tb_n = 6;
    o0 = out_data_q.size(); s0 = stall_cnt;
    pulse_done();
    repeat (8) @(negedge clk);
    pulse_done();
    ok = 0;
    for (int c = 0; c < 80 && ok == 0; c++) begin
      @(negedge clk); #2;
      if (out_data_q.size() - o0 >= 12) ok = 1;
    end
    repeat (10) @(negedge clk);
    #2;
    n_out = out_data_q.size() - o0;
    tests_run++; if (n_out != 12) begin tests_failed++; $display("[TB] FAIL m1_out_count: got %0d, expected 12", n_out); end
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (i >= n_out || out_data_q[o0+i] !== mk(half_base + i / 6, i % 6) || out_last_q[o0+i] !== (i % 6 == 5)) begin
        tests_failed++; $display("[TB] FAIL m1_word[%0d]: got %0h last %0b, expected %0h last %0b", i, out_data_q[o0+i], out_last_q[o0+i], mk(half_base + i / 6, i % 6), (i % 6 == 5));
      end
    end
    tests_run++; if (stall_cnt - s0 != 0) begin tests_failed++; $display("[TB] FAIL m1_no_stall: got %0d stall cycles, expected 0", stall_cnt - s0); end
    half_base += 2;
  endtask

  task automatic test_cfg_during_run;
    int o0, ok, n_out;
    o0 = out_data_q.size();
    pulse_done();
    @(negedge clk);
    cfg_mode = 1'b0; cfg_mode_ld = 1'b1;
    @(negedge clk);
    cfg_mode_ld = 1'b0;
    #2;
    tests_run++; if (buf_mode !== 1'b1) begin tests_failed++; $display("[TB] FAIL cfg_run_ignored: got %0b, expected 1", buf_mode); end
    ok = 0;
    for (int c = 0; c < 60 && ok == 0; c++) begin
      @(negedge clk); #2;
      if (out_data_q.size() - o0 >= 6) ok = 1;
    end
    repeat (5) @(negedge clk);
    lift_idle = 1'b0; cfg_mode_ld = 1'b1;
    @(negedge clk);
    cfg_mode_ld = 1'b0; lift_idle = 1'b1;
    #2;
    tests_run++; if (buf_mode !== 1'b1) begin tests_failed++; $display("[TB] FAIL cfg_busy_ignored: got %0b, expected 1", buf_mode); end
    @(negedge clk);
    cfg_mode_ld = 1'b1;
    @(negedge clk);
    cfg_mode_ld = 1'b0;
    #2;
    tests_run++; if (buf_mode !== 1'b0) begin tests_failed++; $display("[TB] FAIL cfg_drained_loaded: got %0b, expected 0", buf_mode); end
    n_out = out_data_q.size() - o0;
    tests_run++; if (n_out != 6) begin tests_failed++; $display("[TB] FAIL cfg_out_count: got %0d, expected 6", n_out); end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (i >= n_out || out_data_q[o0+i] !== mk(half_base, i) || out_last_q[o0+i] !== (i == 5)) begin
        tests_failed++; $display("[TB] FAIL cfg_word[%0d]: got %0h last %0b, expected %0h last %0b", i, out_data_q[o0+i], out_last_q[o0+i], mk(half_base, i), (i == 5));
      end
    end
    tb_n = 7;
    half_base += 1;
  endtask

  task automatic test_reset_midhalf;
    int o0, i0, found, ok, n_out, n_iss;
    out_ready = 1'b1;
    pulse_done();
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      @(negedge clk); #2;
      if (buf_rd_en && buf_rd_addr == 3'd3) found = 1;
    end
    tests_run++; if (found != 1) begin tests_failed++; $display("[TB] FAIL mid_word3_seen: got %0d, expected 1", found); end
    rst = 1'b1;
    @(negedge clk);
    #2;
    tests_run++; if (buf_rd_en !== 1'b0 || buf_rd_addr !== 3'd0) begin tests_failed++; $display("[TB] FAIL mid_rst_read: got en %0b addr %0d, expected 0 0", buf_rd_en, buf_rd_addr); end
    tests_run++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin tests_failed++; $display("[TB] FAIL mid_rst_stream: got v %0b l %0b d %0h, expected 0 0 0", out_valid, out_last, out_data); end
    tests_run++; if (lift_stall !== 1'b0 || err_overflow !== 1'b0 || buf_mode !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_flags: got %0b%0b%0b, expected 000", lift_stall, err_overflow, buf_mode); end
    rst = 1'b0;
    half_base = 0;
    @(negedge clk);
    i0 = issue_addr_q.size(); o0 = out_data_q.size();
    pulse_done();
    ok = 0;
    for (int c = 0; c < 60 && ok == 0; c++) begin
      @(negedge clk); #2;
      if (out_data_q.size() - o0 >= 7) ok = 1;
    end
    repeat (10) @(negedge clk);
    #2;
    n_iss = issue_addr_q.size() - i0; n_out = out_data_q.size() - o0;
    tests_run++; if (n_iss != 7 || n_out != 7) begin tests_failed++; $display("[TB] FAIL mid_counts: got %0d issues %0d words, expected 7 7", n_iss, n_out); end
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (i >= n_out || out_data_q[o0+i] !== mk(0, i) || out_last_q[o0+i] !== (i == 6)) begin
        tests_failed++; $display("[TB] FAIL mid_word[%0d]: got %0h last %0b, expected %0h last %0b", i, out_data_q[o0+i], out_last_q[o0+i], mk(0, i), (i == 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_single();
    test_backpressure();
    test_overflow();
    test_mode1();
    test_cfg_during_run();
    test_reset_midhalf();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lift_rd_sched.md
LIFT_RD_SCHED -- requirements
Module: lift_rd_sched

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have port cfg_mode  in  1  requested word mode: 0 -> 7 words per half, 1 -> 6 words per half.
REQ-004 SHALL have port cfg_mode_ld  in  1  single-cycle pulse requesting that cfg_mode be loaded.
REQ-005 SHALL have port lift_idle  in  1  high when the lift datapath has no write in progress.
REQ-006 SHALL have port buf_write_done  in  1  single-cycle pulse from the result buffer when a half-buffer (8 banks) is filled.
REQ-007 SHALL have port buf_mode  out  1  active mode, driven to both the buffer and the lift datapath.
REQ-008 SHALL have port buf_rd_addr  out  3  buffer read word address.
REQ-009 SHALL have port buf_rd_en  out  1  read-issue strobe to the buffer; its rise at the last address flips the buffer's read half.
REQ-010 SHALL have port buf_dout  in  240  buffer read data, valid 1 cycle after issue.
REQ-011 SHALL have port lift_stall  out  1  backpressure to the lift datapath.
REQ-012 SHALL have ports out_valid out 1, out_ready in 1, out_data out 240, and out_last out 1, forming the downstream valid/ready stream.
REQ-013 SHALL have port err_overflow  out  1  sticky overflow error flag.

Function
REQ-014 SHALL keep full_cnt (0..2), the count of filled, unread halves.
- +1 on buf_write_done.
- -1 when the last word of a half is issued.
- Both in the same cycle: no change.
REQ-015 SHALL drive lift_stall = (full_cnt==2), combinationally from the register.
REQ-016 SHALL, on buf_write_done while full_cnt==2, set err_overflow (sticky until rst) and hold full_cnt at 2.
REQ-017 SHALL use a two-state FSM:
- IDLE->RUN when full_cnt>0.
- RUN->IDLE on issue of the last word when the post-update full_cnt==0.
- Otherwise RUN continues with word counter k reset to 0.
REQ-018 SHALL set N=7 when buf_mode=0 and N=6 when buf_mode=1; the last word is k==N-1.
REQ-019 SHALL, in RUN, issue word k (buf_rd_en=1, buf_rd_addr=k) only when inflight + fifo_cnt - pop < 2, where pop = out_valid & out_ready.
REQ-020 SHALL assert buf_rd_en for exactly one cycle per word, and SHALL hold buf_rd_addr at 0 while buf_rd_en is 0.
REQ-021 SHALL capture buf_dout into a 2-entry FIFO on the cycle after issue, tagging out_last on word N-1.
REQ-022 SHALL have issue-to-out_valid latency of exactly 2 cycles when the FIFO is empty.
REQ-023 SHALL sustain 1 word per cycle while out_ready=1.
REQ-024 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL never deassert out_valid without a handshake.
REQ-026 SHALL accept cfg_mode_ld only when quiescent: IDLE, full_cnt==0, FIFO empty, no inflight read, and lift_idle=1.
- When accepted, buf_mode <= cfg_mode on the next edge.
- Otherwise the pulse SHALL be ignored.
REQ-027 SHALL allow simultaneous push and pop on a full FIFO; occupancy is unchanged.

Reset
REQ-028 SHALL, on rst, set the following, with rst taking priority over all other events including mid-half reads:
- state=IDLE, full_cnt=0, k=0, inflight=0, FIFO empty.
- buf_mode=0, buf_rd_en=0, buf_rd_addr=0.
- out_valid=0, out_last=0, out_data=0.
- lift_stall=0, err_overflow=0.
REQ-029 SHALL require the result buffer to be reset in the same cycle; partial halves are discarded.

Structure
REQ-030 SHALL place the following in a shared package: WORD_W=30, BANKS=8, LINE_W=240, N_MODE0=7, N_MODE1=6, and the state enum {IDLE, RUN}.
REQ-031 SHALL implement the 2-entry 240-bit FIFO (with last tag) as one sub-module, lift_rd_fifo2; everything else is flat.

Verification
REQ-032 Mode 0, one buf_write_done pulse, out_ready=1 -> 7 words issued on addresses 0..6 on consecutive cycles, out_valid 2 cycles after first issue, out_last only on the 7th word, full_cnt returns to 0.
REQ-033 Mode 1 loaded while quiescent, two pulses 10 cycles apart, out_ready=1 -> 12 words total, out_last on words 6 and 12, lift_stall=0 throughout.
REQ-034 Three buf_write_done pulses with out_ready=0 -> lift_stall=1 after the 2nd pulse, err_overflow=1 after the 3rd, and at most 2 reads issued.
REQ-035 out_ready toggled 1/0 each cycle -> no word lost or duplicated, out_data stable while stalled, data order matches the buffer contents.
REQ-036 cfg_mode_ld pulsed during RUN -> buf_mode unchanged; repeated after drain with lift_idle=1 -> buf_mode updates on the next edge.
REQ-037 rst asserted at word 3 of a half -> all outputs at reset values next cycle, and a fresh pulse then yields a correct 7-word sequence.
